// File: rtl/fifo18kx2_drain_arbiter.sv
// ----------------------------------------------------------------------------
// fifo18kx2_drain_arbiter
//
// Round-robin read scheduler for the two read ports of one FIFO18KX2.
// Reads are granted in bounded bursts (at most BURST_MAX per tenure).
// The 1-cycle RD_DATA latency is absorbed into a 2-entry skid buffer.
// Both channels are merged into one valid/ready stream. M_SRC tags each word
// with its source channel.
//
// Parameters:
//   DATA_WIDTH  width of RD_DATA1/2 and M_DATA (1..18)
//   BURST_MAX   max consecutive reads granted to one channel per tenure (>=1)
//
// Ports:
//   CLK                 clock, also the FIFO read clocks
//   RESET               synchronous active-high reset
//   EMPTY1/2            FIFO empty flags
//   UNDERFLOW1/2        FIFO underflow flags (fold into sticky ERR)
//   RD_DATA1/2          FIFO read data, valid the cycle after RD_EN1/2
//   RD_EN1/2            FIFO read enables (never both high)
//   M_DATA, M_SRC       merged output word and source (0 = FIFO1, 1 = FIFO2)
//   M_VALID, M_READY    output handshake
//   BUSY                grant active, read in flight or buffer non-empty
//   ERR                 sticky underflow indication
//
// Optional feature: define FIFO18KX2_DRAIN_ARB_STATS_EN to add the WORDS1 and
// WORDS2 outputs. These are 16-bit wrapping counts of delivered words per source.
// ----------------------------------------------------------------------------
module fifo18kx2_drain_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int BURST_MAX  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EMPTY1,
  input  logic                  UNDERFLOW1,
  input  logic [DATA_WIDTH-1:0] RD_DATA1,
  output logic                  RD_EN1,
  input  logic                  EMPTY2,
  input  logic                  UNDERFLOW2,
  input  logic [DATA_WIDTH-1:0] RD_DATA2,
  output logic                  RD_EN2,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_SRC,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic                  BUSY,
  output logic                  ERR
`ifdef FIFO18KX2_DRAIN_ARB_STATS_EN
  ,
  output logic [15:0]           WORDS1,
  output logic [15:0]           WORDS2
`endif
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  typedef struct packed {
    logic                  src;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q;
  logic             last_served_q;   // 0 = CH1, 1 = CH2
  logic             inflight_q;
  logic             inflight_src_q;
  entry_t           buf_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             err_q;

  logic             push, pop, space_ok, grant_exit;
  logic [2:0]       room_calc;
  entry_t           push_entry;

  // The buffer pops when the consumer takes a word. It pushes when the word
  // read last cycle arrives on RD_DATA.
  assign pop        = M_VALID && M_READY;
  assign push       = inflight_q;
  assign push_entry = '{src: inflight_src_q,
                        data: inflight_src_q ? RD_DATA2 : RD_DATA1};

  // Reserve a slot for the in-flight word and credit this cycle's pop, so a
  // new read never overflows the buffer but full throughput is kept.
  assign room_calc = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign space_ok  = (room_calc < 3'd2);

  // ---------------- FSM: state register ----------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!EMPTY1 && !EMPTY2) state_d = last_served_q ? GRANT1 : GRANT2;
        else if (!EMPTY1)       state_d = GRANT1;
        else if (!EMPTY2)       state_d = GRANT2;
      end
      GRANT1: if (EMPTY1 || (RD_EN1 && burst_cnt_q == BURST_LAST)) state_d = IDLE;
      GRANT2: if (EMPTY2 || (RD_EN2 && burst_cnt_q == BURST_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Read enables are gated by RESET combinationally, so no read is issued
  // while reset is held.
  always_comb begin
    RD_EN1 = 1'b0;
    RD_EN2 = 1'b0;
    if (!RESET) begin
      RD_EN1 = (state_q == GRANT1) && !EMPTY1 && space_ok;
      RD_EN2 = (state_q == GRANT2) && !EMPTY2 && space_ok;
    end
  end

  assign grant_exit = (state_q != IDLE) && (state_d == IDLE);

  // Burst counter and round-robin pointer. An exit with zero reads still
  // hands priority to the other channel.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      burst_cnt_q   <= '0;
      last_served_q <= 1'b1;
    end else if (grant_exit) begin
      burst_cnt_q   <= '0;
      last_served_q <= (state_q == GRANT2);
    end else if (RD_EN1 || RD_EN2) begin
      burst_cnt_q   <= burst_cnt_q + 1'b1;
    end
  end

  // In-flight tracking; a read issued just before reset is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= 1'b0;
    end else begin
      inflight_q     <= RD_EN1 || RD_EN2;
      inflight_src_q <= RD_EN2;
    end
  end

  // ---------------- 2-entry output buffer ----------------
  // NOTE: buffer storage is not reset; validity comes from count_q alone,
  // and the outputs are masked while the buffer is empty.
  always_ff @(posedge CLK) begin
    if (push) buf_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign M_VALID = (count_q != 2'd0);
  assign M_DATA  = M_VALID ? buf_q[rd_ptr_q].data : '0;
  assign M_SRC   = M_VALID ? buf_q[rd_ptr_q].src  : 1'b0;
  assign BUSY    = (state_q != IDLE) || inflight_q || M_VALID;

  // ---------------- sticky error ----------------
  always_ff @(posedge CLK) begin
    if (RESET)                         err_q <= 1'b0;
    else if (UNDERFLOW1 || UNDERFLOW2) err_q <= 1'b1;
  end
  assign ERR = err_q;

`ifdef FIFO18KX2_DRAIN_ARB_STATS_EN
  // ---------------- delivered-word statistics ----------------
  logic [15:0] words1_q, words2_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      words1_q <= '0;
      words2_q <= '0;
    end else if (pop) begin
      if (M_SRC) words2_q <= words2_q + 16'd1;
      else       words1_q <= words1_q + 16'd1;
    end
  end

  assign WORDS1 = words1_q;
  assign WORDS2 = words2_q;
`endif

endmodule

// File: tb/tb_fifo18kx2_drain_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo18kx2_drain_arbiter
//
// Directed bench for fifo18kx2_drain_arbiter. Two behavioural FIFOs feed the DUT.
// In each FIFO, EMPTY is updated by the edge that consumes RD_EN, and RD_DATA
// is valid one cycle later. Every delivered word is logged with its cycle
// number. The log is compared against hand-derived sequences.
// ----------------------------------------------------------------------------
module tb_fifo18kx2_drain_arbiter;

  localparam int DW = 18;
  localparam int BM = 4;

  logic          CLK = 1'b0;
  logic          RESET, EMPTY1, EMPTY2, UNDERFLOW1, UNDERFLOW2, M_READY;
  logic [DW-1:0] RD_DATA1, RD_DATA2, M_DATA;
  logic          RD_EN1, RD_EN2, M_SRC, M_VALID, BUSY, ERR;
`ifdef FIFO18KX2_DRAIN_ARB_STATS_EN
  logic [15:0]   WORDS1, WORDS2;
`endif

  always #5 CLK = ~CLK;

  fifo18kx2_drain_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .CLK(CLK), .RESET(RESET),
    .EMPTY1(EMPTY1), .UNDERFLOW1(UNDERFLOW1), .RD_DATA1(RD_DATA1), .RD_EN1(RD_EN1),
    .EMPTY2(EMPTY2), .UNDERFLOW2(UNDERFLOW2), .RD_DATA2(RD_DATA2), .RD_EN2(RD_EN2),
    .M_DATA(M_DATA), .M_SRC(M_SRC), .M_VALID(M_VALID), .M_READY(M_READY),
    .BUSY(BUSY), .ERR(ERR)
`ifdef FIFO18KX2_DRAIN_ARB_STATS_EN
    , .WORDS1(WORDS1), .WORDS2(WORDS2)
`endif
  );

  // ---------------- behavioural FIFO pair ----------------
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem2 [1024];
  int head1 = 0, head2 = 0, tail1 = 0, tail2 = 0;

  assign EMPTY1 = (head1 == tail1);
  assign EMPTY2 = (head2 == tail2);

  always @(posedge CLK) begin
    if (RD_EN1) begin
      RD_DATA1 <= mem1[head1];
      head1    <= head1 + 1;
    end
    if (RD_EN2) begin
      RD_DATA2 <= mem2[head2];
      head2    <= head2 + 1;
    end
  end

  task automatic load1(input logic [DW-1:0] d);
    mem1[tail1] = d;
    tail1++;
  endtask

  task automatic load2(input logic [DW-1:0] d);
    mem2[tail2] = d;
    tail2++;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- per-cycle monitor ----------------
  int          cyc = 0;
  logic [DW:0] out_q[$];
  int          out_cyc[$];
  int          rd1_cyc[$];
  int          rd2_cyc[$];
  int          dual, stall_err, max_out, reads, delivered;
  logic        prev_stall;
  logic [DW:0] prev_word;

  task automatic clear_log();
    out_q.delete(); out_cyc.delete(); rd1_cyc.delete(); rd2_cyc.delete();
    dual = 0; stall_err = 0; max_out = 0; reads = 0; delivered = 0;
    prev_stall = 1'b0; prev_word = '0;
  endtask

  // One clock: set M_READY after the negedge, then sample. The values seen
  // here are the ones the next posedge acts on.
  task automatic step(input logic rdy);
    @(negedge CLK);
    M_READY = rdy;
    #1;
    cyc++;
    if (RD_EN1 && RD_EN2) dual++;
    if (prev_stall && (!M_VALID || {M_SRC, M_DATA} != prev_word)) stall_err++;
    if (reads - delivered > max_out) max_out = reads - delivered;
    if (RD_EN1) begin rd1_cyc.push_back(cyc); reads++; end
    if (RD_EN2) begin rd2_cyc.push_back(cyc); reads++; end
    if (M_VALID && M_READY) begin
      out_q.push_back({M_SRC, M_DATA});
      out_cyc.push_back(cyc);
      delivered++;
    end
    prev_stall = M_VALID && !M_READY;
    prev_word  = {M_SRC, M_DATA};
  endtask

  task automatic run_words(input int n, input int budget, input int pct);
    for (int i = 0; i < budget && out_q.size() < n; i++)
      step($urandom_range(0, 99) < pct);
  endtask

  task automatic run_cycles(input int n, input int pct);
    for (int i = 0; i < n; i++) step($urandom_range(0, 99) < pct);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && (BUSY || !EMPTY1 || !EMPTY2); i++) step(1'b1);
    check(tag, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    step(1'b0);
    step(1'b0);
    RESET = 1'b0;
    clear_log();
  endtask

  // Expected word for source src, sequence index idx, data base.
  function automatic logic [DW:0] word(input logic src, input logic [DW-1:0] base, input int idx);
    logic [DW-1:0] d;
    d = base + DW'(idx);
    return {src, d};
  endfunction

  // Watchdog: never hang on a stuck design.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blocks[6] = '{4, 4, 4, 4, 2, 2};
    int i1, i2, k, e1, e2, bad;
    logic [DW:0] got, exp_w;

    RESET = 1'b1; UNDERFLOW1 = 1'b0; UNDERFLOW2 = 1'b0; M_READY = 1'b0;
    clear_log();

    // ---- reset state ----
    step(1'b0);
    step(1'b0);
    check("rst_rd_en1", {31'd0, RD_EN1}, 32'd0);
    check("rst_rd_en2", {31'd0, RD_EN2}, 32'd0);
    check("rst_m_valid", {31'd0, M_VALID}, 32'd0);
    check("rst_m_data", {14'd0, M_DATA}, 32'd0);
    check("rst_m_src", {31'd0, M_SRC}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    RESET = 1'b0;
    clear_log();

    // ---- test 1: FIFO1 holds A,B,C, FIFO2 empty ----
    load1(18'h0000A); load1(18'h0000B); load1(18'h0000C);
    run_words(3, 40, 100);
    run_cycles(4, 100);
    check("t1_reads", rd1_cyc.size(), 3);
    check("t1_words", out_q.size(), 3);
    if (rd1_cyc.size() == 3 && out_q.size() == 3) begin
      check("t1_reads_consecutive", rd1_cyc[2] - rd1_cyc[0], 2);
      check("t1_latency", out_cyc[0] - rd1_cyc[0], 2);
      check("t1_words_consecutive", out_cyc[2] - out_cyc[0], 2);
      check("t1_w0", out_q[0], {1'b0, 18'h0000A});
      check("t1_w1", out_q[1], {1'b0, 18'h0000B});
      check("t1_w2", out_q[2], {1'b0, 18'h0000C});
    end
    drain("t1_idle", 20);

    // ---- test 2: both hold 10 words, round-robin bursts of 4 ----
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      load1(18'h10000 + 18'(i));
      load2(18'h20000 + 18'(i));
    end
    run_words(20, 200, 100);
    check("t2_words", out_q.size(), 20);
    i1 = 0; i2 = 0; k = 0;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < blocks[b]; j++) begin
        if (b % 2 == 0) begin exp_w = word(1'b0, 18'h10000, i1); i1++; end
        else            begin exp_w = word(1'b1, 18'h20000, i2); i2++; end
        got = (k < out_q.size()) ? out_q[k] : '1;
        check($sformatf("t2_w%0d", k), got, exp_w);
        k++;
      end
    end
    check("t2_no_dual_rd_en", dual, 0);
    drain("t2_idle", 20);

    // ---- test 3: both loaded, M_READY 30% for 200 cycles ----
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      load1(18'h11000 + 18'(i));
      load2(18'h21000 + 18'(i));
    end
    run_cycles(200, 30);
    run_words(80, 300, 100);
    check("t3_words", out_q.size(), 80);
    e1 = 0; e2 = 0; bad = 0;
    foreach (out_q[n]) begin
      if (out_q[n][DW] == 1'b0) begin
        if (out_q[n] != word(1'b0, 18'h11000, e1)) bad++;
        e1++;
      end else begin
        if (out_q[n] != word(1'b1, 18'h21000, e2)) bad++;
        e2++;
      end
    end
    check("t3_ch1_count", e1, 40);
    check("t3_ch2_count", e2, 40);
    check("t3_order_errors", bad, 0);
    check("t3_stall_stable_errors", stall_err, 0);
    check("t3_outstanding_le2", {31'd0, max_out <= 2}, 32'd1);
    check("t3_no_dual_rd_en", dual, 0);
    drain("t3_idle", 20);

    // ---- test 4: reset mid-burst in GRANT2 ----
    reset_dut();
    for (int i = 0; i < 6; i++) load2(18'h22000 + 18'(i));
    for (int i = 0; i < 20 && rd2_cyc.size() < 2; i++) step(1'b1);
    check("t4_reached_grant2", rd2_cyc.size(), 2);
    RESET = 1'b1;
    #1;
    check("t4_rd_en2_gated", {31'd0, RD_EN2}, 32'd0);
    step(1'b1);
    check("t4_m_valid", {31'd0, M_VALID}, 32'd0);
    check("t4_m_data", {14'd0, M_DATA}, 32'd0);
    check("t4_m_src", {31'd0, M_SRC}, 32'd0);
    check("t4_busy", {31'd0, BUSY}, 32'd0);
    check("t4_rd_en", {30'd0, RD_EN1, RD_EN2}, 32'd0);
    RESET = 1'b0;
    clear_log();
    for (int i = 0; i < 3; i++) load1(18'h12000 + 18'(i));
    for (int i = 0; i < 10 && rd1_cyc.size() + rd2_cyc.size() == 0; i++) step(1'b1);
    check("t4_first_ch1", rd1_cyc.size(), 1);
    check("t4_first_not_ch2", rd2_cyc.size(), 0);
    drain("t4_idle", 60);

    // ---- test 5: UNDERFLOW2 pulse ----
    reset_dut();
    check("t5_err_clear_initially", {31'd0, ERR}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      load1(18'h13000 + 18'(i));
      load2(18'h23000 + 18'(i));
    end
    step(1'b1);
    UNDERFLOW2 = 1'b1;
    step(1'b1);
    UNDERFLOW2 = 1'b0;
    check("t5_err_set", {31'd0, ERR}, 32'd1);
    run_words(6, 60, 100);
    check("t5_err_held", {31'd0, ERR}, 32'd1);
    check("t5_words", out_q.size(), 6);
    for (int n = 0; n < 6; n++) begin
      exp_w = (n < 3) ? word(1'b0, 18'h13000, n) : word(1'b1, 18'h23000, n - 3);
      got   = (n < out_q.size()) ? out_q[n] : '1;
      check($sformatf("t5_w%0d", n), got, exp_w);
    end
    reset_dut();
    check("t5_err_cleared", {31'd0, ERR}, 32'd0);

`ifdef FIFO18KX2_DRAIN_ARB_STATS_EN
    // ---- test 6: delivered-word statistics ----
    check("t6_words1_reset", {16'd0, WORDS1}, 32'd0);
    for (int i = 0; i < 7; i++) load1(18'h14000 + 18'(i));
    for (int i = 0; i < 5; i++) load2(18'h24000 + 18'(i));
    run_words(12, 100, 100);
    check("t6_words1", {16'd0, WORDS1}, 32'd7);
    check("t6_words2", {16'd0, WORDS2}, 32'd5);
    force dut.words1_q = 16'hFFFF;
    step(1'b0);
    release dut.words1_q;
    clear_log();
    load1(18'h15000);
    run_words(1, 20, 100);
    check("t6_words1_wrap", {16'd0, WORDS1}, 32'd0);
    check("t6_words2_kept", {16'd0, WORDS2}, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
